// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the byte/half/word data-memory controller.
package mem_pkg;
  typedef enum logic [2:0] {
    OP_LW = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
    OP_LHU = 3'd4, OP_SW = 3'd5, OP_SB = 3'd6, OP_SH = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, FIN} state_t;

  localparam int          DM_WORDS = 3073;
  localparam logic [31:0] DM_LIMIT = 32'(DM_WORDS * 4);  // 0x3004

  function automatic logic is_word(input mem_op_t o);
    return (o == OP_LW) || (o == OP_SW);
  endfunction

  function automatic logic is_half(input mem_op_t o);
    return (o == OP_LH) || (o == OP_LHU) || (o == OP_SH);
  endfunction

  function automatic logic is_store(input mem_op_t o);
    return (o == OP_SW) || (o == OP_SB) || (o == OP_SH);
  endfunction

  function automatic logic is_illegal(input mem_op_t o, input logic [31:0] a);
    logic bad;
    bad = (a[31:16] != 16'h0) || (a >= DM_LIMIT);
    if (is_word(o) && (a[1:0] != 2'b00)) bad = 1'b1;
    if (is_half(o) && a[0]) bad = 1'b1;
    return bad;
  endfunction
endpackage

// File: rtl/load_ext.sv
// Load-result extension: raw word (or {hi8,lo8} in bits 15:0) to architectural rdata.
module load_ext
  import mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [31:0] raw,
  output logic [31:0] rdata
);
  always_comb begin
    rdata = raw;
    case (op)
      OP_LB:   rdata = {{24{raw[7]}}, raw[7:0]};
      OP_LBU:  rdata = {24'h0, raw[7:0]};
      OP_LH:   rdata = {{16{raw[15]}}, raw[15:0]};
      OP_LHU:  rdata = {16'h0, raw[15:0]};
      default: rdata = raw;
    endcase
  end
endmodule

// File: rtl/mem_ctrl.sv
// Sequences one load/store per request onto a word/byte data memory;
// halfwords take two byte-mode accesses, low byte first.
module mem_ctrl
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [13:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  output logic        dm_bmode,
  output logic [1:0]  dm_bsel,
  input  logic [31:0] dm_dout
);
  state_t      state;
  mem_op_t     op_q;
  mem_op_t     op_in;
  logic [7:0]  whi_q;
  logic [7:0]  lo_q;
  logic        we_q;
  logic [31:0] raw;
  logic [31:0] ext;

  assign op_in = mem_op_t'(op);

  // Second half access reassembles the halfword from the captured low byte.
  assign raw = (state == ACC1) ? {16'h0, dm_dout[7:0], lo_q} : dm_dout;

  load_ext u_ext (.op(op_q), .raw(raw), .rdata(ext));

  // A write whose edge coincides with reset must never reach the memory.
  assign dm_we = we_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 32'h0;
      we_q     <= 1'b0;
      dm_bmode <= 1'b0;
      dm_addr  <= 14'h0;
      dm_bsel  <= 2'b00;
      dm_din   <= 32'h0;
      op_q     <= OP_LW;
      whi_q    <= 8'h0;
      lo_q     <= 8'h0;
    end else begin
      case (state)
        IDLE: if (req) begin
          op_q  <= op_in;
          whi_q <= wdata[15:8];
          busy  <= 1'b1;
          if (is_illegal(op_in, addr)) begin
            state <= FIN;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            state    <= ACC0;
            dm_addr  <= addr[15:2];
            dm_bmode <= ~is_word(op_in);
            dm_bsel  <= addr[1:0];
            we_q     <= is_store(op_in);
            dm_din   <= is_word(op_in) ? wdata : {24'h0, wdata[7:0]};
          end
        end
        ACC0: begin
          lo_q <= dm_dout[7:0];
          if (is_half(op_q)) begin
            state   <= ACC1;
            dm_bsel <= dm_bsel + 2'd1;
            dm_din  <= {24'h0, whi_q};
          end else begin
            state    <= FIN;
            done     <= 1'b1;
            we_q     <= 1'b0;
            dm_bmode <= 1'b0;
            if (!is_store(op_q)) rdata <= ext;
          end
        end
        ACC1: begin
          state    <= FIN;
          done     <= 1'b1;
          we_q     <= 1'b0;
          dm_bmode <= 1'b0;
          if (!is_store(op_q)) rdata <= ext;
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl against a behavioural word/byte memory.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, req;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [13:0] dm_addr;
  logic [31:0] dm_din;
  logic        dm_we, dm_bmode;
  logic [1:0]  dm_bsel;
  logic [31:0] dm_dout;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int acc_cyc[$];
  logic [9:0] wlog[$];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk_rd;
    int          lat;
    int          nwe;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:3072];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_bmode(dm_bmode),
    .dm_bsel(dm_bsel), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [31:0] w;
    logic [7:0]  b;
    w = (dm_addr < 14'd3073) ? mem[dm_addr] : 32'h0;
    b = w[8*dm_bsel +: 8];
    dm_dout = dm_bmode ? {{24{b[7]}}, b} : w;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dm_we && dm_addr < 14'd3073) begin
      if (dm_bmode) mem[dm_addr][8*dm_bsel +: 8] <= dm_din[7:0];
      else          mem[dm_addr] <= dm_din;
    end
    if (dm_we) begin
      we_cnt <= we_cnt + 1;
      wlog.push_back({dm_bsel, dm_din[7:0]});
    end
    if (req && !busy && !rst) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                        input logic e_err, input logic [31:0] e_rd, input logic chk_rd,
                        input int e_lat, input int e_nwe, input string nm);
    exp_t e;
    int n, we0;
    sb.push_back('{err: e_err, rdata: e_rd, chk_rd: chk_rd, lat: e_lat, nwe: e_nwe});
    @(negedge clk);
    op = o; addr = a; wdata = w; req = 1'b1;
    we0 = we_cnt;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s done timeout: no done within 10 cycles, required latency %0d", nm, e.lat);
    end else begin
      if (n + 1 !== e.lat) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", nm, n + 1, e.lat);
      end
      checks++;
      if (err !== e.err) begin
        errors++;
        $display("FAIL %s err: got %b required %b", nm, err, e.err);
      end
      checks++;
      if (we_cnt - we0 !== e.nwe) begin
        errors++;
        $display("FAIL %s write count: got %0d required %0d", nm, we_cnt - we0, e.nwe);
      end
      if (e.chk_rd) begin
        checks++;
        if (rdata !== e.rdata) begin
          errors++;
          $display("FAIL %s rdata: got %h required %h", nm, rdata, e.rdata);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, dm_we, dm_bmode} !== 5'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset state: busy=%b done=%b err=%b we=%b bmode=%b rdata=%h required all 0",
               busy, done, err, dm_we, dm_bmode, rdata);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_word();
    access(3'd5, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 2, 1, "SW 0x10");
    access(3'd0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 2, 0, "LW 0x10");
  endtask

  task automatic test_byte();
    access(3'd6, 32'h13, 32'h85, 1'b0, 32'h0, 1'b0, 2, 1, "SB 0x13");
    access(3'd1, 32'h13, 32'h0, 1'b0, 32'hFFFFFF85, 1'b1, 2, 0, "LB 0x13");
    access(3'd2, 32'h13, 32'h0, 1'b0, 32'h00000085, 1'b1, 2, 0, "LBU 0x13");
    access(3'd0, 32'h10, 32'h0, 1'b0, 32'h85ADBEEF, 1'b1, 2, 0, "LW 0x10 after SB");
  endtask

  task automatic test_half();
    wlog.delete();
    access(3'd7, 32'h22, 32'h8001, 1'b0, 32'h0, 1'b0, 3, 2, "SH 0x22");
    checks++;
    if (wlog.size() != 2) begin
      errors++;
      $display("FAIL SH lanes: got %0d write beats required 2", wlog.size());
    end else if (wlog[0] !== {2'd2, 8'h01} || wlog[1] !== {2'd3, 8'h80}) begin
      errors++;
      $display("FAIL SH lanes: got %h,%h required 201,380", wlog[0], wlog[1]);
    end
    access(3'd3, 32'h22, 32'h0, 1'b0, 32'hFFFF8001, 1'b1, 3, 0, "LH 0x22");
    access(3'd4, 32'h22, 32'h0, 1'b0, 32'h00008001, 1'b1, 3, 0, "LHU 0x22");
  endtask

  task automatic test_illegal();
    access(3'd0, 32'h12,   32'h0,        1'b1, 32'h00008001, 1'b1, 1, 0, "LW 0x12");
    access(3'd7, 32'h21,   32'h1234,     1'b1, 32'h00008001, 1'b1, 1, 0, "SH 0x21");
    access(3'd5, 32'h3004, 32'hCAFEF00D, 1'b1, 32'h00008001, 1'b1, 1, 0, "SW 0x3004");
    access(3'd5, 32'h10000, 32'h1,       1'b1, 32'h00008001, 1'b1, 1, 0, "SW 0x10000");
    access(3'd0, 32'h3000, 32'h0,        1'b0, 32'h0,        1'b1, 2, 0, "LW 0x3000 last word");
  endtask

  task automatic test_back_to_back();
    int a0, d0, n;
    a0 = acc_cnt; d0 = done_cnt;
    acc_cyc.delete();
    @(negedge clk);
    op = 3'd0; addr = 32'h10; req = 1'b1;
    n = 0;
    while (acc_cnt - a0 < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (acc_cnt - a0 !== 2 || done_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL held req: accepts=%0d dones=%0d required 2 and 2", acc_cnt - a0, done_cnt - d0);
    end
    checks++;
    if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] !== 3) begin
      errors++;
      $display("FAIL back-to-back gap: got %0d accepts, gap %0d required gap 3",
               acc_cyc.size(), (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1);
    end
    checks++;
    if (rdata !== 32'h85ADBEEF) begin
      errors++;
      $display("FAIL held req rdata: got %h required 85adbeef", rdata);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    access(3'd5, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, 2, 1, "SW 0x40 clear");
    d0 = done_cnt;
    @(negedge clk);
    op = 3'd7; addr = 32'h40; wdata = 32'hBBAA; req = 1'b1;
    @(posedge clk); #1;          // accept, now in ACC0
    req = 1'b0;
    @(posedge clk); #1;          // low byte written, now in ACC1
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset abort state: busy=%b done=%b required 0 0", busy, done);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL reset abort done: got %0d pulses required 0", done_cnt - d0);
    end
    checks++;
    if (mem[16] !== 32'h000000AA) begin
      errors++;
      $display("FAIL reset abort memory: word 0x40 got %h required 000000aa", mem[16]);
    end
  endtask

  initial begin
    for (int i = 0; i < 3073; i++) mem[i] = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
